// File: rtl/serial_subtractor_if.sv
// Operand/result bundle for the bit-serial subtractor.
interface serial_subtractor_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow;

    modport master (
        output start, a, b,
        input  busy, done, diff, borrow
    );

    modport slave (
        input  start, a, b,
        output busy, done, diff, borrow
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: one bit per clock, LSB first.
// Result and borrow appear WIDTH cycles after start is accepted.
module serial_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input logic               clk,
    input logic               rst,
    serial_subtractor_if.slave bus
);
    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic [WIDTH-1:0] res_next;
    logic [CW-1:0]    cnt;
    logic             br;
    logic             br_next;
    logic             d;
    logic             last;
    logic [WIDTH-1:0] diff_q;
    logic             borrow_q;

    // Full-subtractor slice on the current LSBs plus next result word
    always_comb begin
        d        = a_sr[0] ^ b_sr[0] ^ br;
        br_next  = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br);
        res_next = {d, res_sr[WIDTH-1:1]};
        last     = (cnt == CW'(WIDTH - 1));
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; start is only honoured outside SHIFT
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start) state_next = SHIFT;
            SHIFT:   if (last)      state_next = DONE;
            DONE:    state_next = bus.start ? SHIFT : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Operand latch, serial datapath and result capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sr     <= '0;
            b_sr     <= '0;
            res_sr   <= '0;
            br       <= 1'b0;
            cnt      <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        a_sr   <= bus.a;
                        b_sr   <= bus.b;
                        res_sr <= '0;
                        br     <= 1'b0;
                        cnt    <= '0;
                    end
                end
                SHIFT: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    res_sr <= res_next;
                    br     <= br_next;
                    if (last) begin
                        diff_q   <= res_next;
                        borrow_q <= br_next;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Status decodes straight from the state flop; no input-to-output path
    always_comb begin
        bus.busy   = (state == SHIFT);
        bus.done   = (state == DONE);
        bus.diff   = diff_q;
        bus.borrow = borrow_q;
    end
endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and random checks for serial_subtractor at WIDTH=8.
module tb_serial_subtractor;
    localparam int unsigned WIDTH = 8;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    serial_subtractor_if #(.WIDTH(WIDTH)) bus ();

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present operands before a rising edge and drop start after it
    task automatic start_op(input logic [7:0] av, input logic [7:0] bv);
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = av;
        bus.b     = bv;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    // Cycles from now until done rises (bounded), and busy samples seen
    task automatic wait_done(output int lat, output int busy_cnt);
        lat      = 0;
        busy_cnt = 0;
        while (bus.done !== 1'b1 && lat < WIDTH + 6) begin
            if (bus.busy === 1'b1) busy_cnt++;
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic test_reset;
        #3;
        n_cmp++;
        if ({bus.busy, bus.done, bus.diff, bus.borrow} !== 11'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got busy=%b done=%b diff=%h borrow=%b, want all 0",
                     bus.busy, bus.done, bus.diff, bus.borrow);
        end
        @(negedge clk);
        rst       = 1'b0;
        bus.start = 1'b1;
        bus.a     = 8'h35;
        bus.b     = 8'h12;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        n_cmp++;
        if (bus.busy !== 1'b1) begin
            n_err++;
            $display("FAIL reset_first_accept: busy=%b, want 1", bus.busy);
        end
        begin
            int lat, bc;
            wait_done(lat, bc);
            n_cmp++;
            if (bus.diff !== 8'h23 || bus.borrow !== 1'b0) begin
                n_err++;
                $display("FAIL reset_first_result: diff=%h borrow=%b, want 23/0", bus.diff, bus.borrow);
            end
        end
    endtask

    task automatic test_vectors;
        logic [7:0] va [4] = '{8'h35, 8'h12, 8'h00, 8'hFF};
        logic [7:0] vb [4] = '{8'h12, 8'h35, 8'h01, 8'hFF};
        logic [7:0] vd [4] = '{8'h23, 8'hDD, 8'hFF, 8'h00};
        logic       vr [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            int lat, bc;
            start_op(va[i], vb[i]);
            wait_done(lat, bc);
            n_cmp++;
            if (lat !== WIDTH || bc !== WIDTH) begin
                n_err++;
                $display("FAIL vec%0d_timing: latency=%0d busy_cycles=%0d, want %0d/%0d",
                         i, lat, bc, WIDTH, WIDTH);
            end
            n_cmp++;
            if (bus.diff !== vd[i] || bus.borrow !== vr[i]) begin
                n_err++;
                $display("FAIL vec%0d_result: diff=%h borrow=%b, want %h/%b",
                         i, bus.diff, bus.borrow, vd[i], vr[i]);
            end
            @(posedge clk);
            #1;
            n_cmp++;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
                n_err++;
                $display("FAIL vec%0d_after: done=%b busy=%b, want 0/0", i, bus.done, bus.busy);
            end
        end
    endtask

    task automatic test_ignore_start;
        int lat, bc, pulses;
        start_op(8'h35, 8'h12);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        bus.start = 1'b1;
        bus.a     = 8'h99;
        bus.b     = 8'h44;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_done(lat, bc);
        n_cmp++;
        if (lat + 4 !== WIDTH) begin
            n_err++;
            $display("FAIL ignore_latency: latency=%0d, want %0d", lat + 4, WIDTH);
        end
        n_cmp++;
        if (bus.diff !== 8'h23 || bus.borrow !== 1'b0) begin
            n_err++;
            $display("FAIL ignore_result: diff=%h borrow=%b, want 23/0", bus.diff, bus.borrow);
        end
        pulses = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1 || bus.busy === 1'b1) pulses++;
        end
        n_cmp++;
        if (pulses !== 0) begin
            n_err++;
            $display("FAIL ignore_single_done: extra busy/done cycles=%0d, want 0", pulses);
        end
    endtask

    task automatic test_back_to_back;
        int lat, bc;
        start_op(8'h35, 8'h12);
        wait_done(lat, bc);
        bus.start = 1'b1;
        bus.a     = 8'h80;
        bus.b     = 8'h01;
        n_cmp++;
        if (bus.done !== 1'b1 || bus.diff !== 8'h23 || bus.borrow !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_first: done=%b diff=%h borrow=%b, want 1/23/0",
                     bus.done, bus.diff, bus.borrow);
        end
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        n_cmp++;
        if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_rebusy: busy=%b done=%b, want 1/0", bus.busy, bus.done);
        end
        wait_done(lat, bc);
        n_cmp++;
        if (lat !== WIDTH || bus.diff !== 8'h7F || bus.borrow !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_second: latency=%0d diff=%h borrow=%b, want %0d/7f/0",
                     lat, bus.diff, bus.borrow, WIDTH);
        end
    endtask

    task automatic test_async_reset;
        int lat, bc, dones;
        start_op(8'hA5, 8'h5A);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({bus.busy, bus.done, bus.diff, bus.borrow} !== 11'd0) begin
            n_err++;
            $display("FAIL async_rst_outputs: busy=%b done=%b diff=%h borrow=%b, want all 0",
                     bus.busy, bus.done, bus.diff, bus.borrow);
        end
        #13;
        rst = 1'b0;
        dones = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1 || bus.busy === 1'b1) dones++;
        end
        n_cmp++;
        if (dones !== 0 || bus.diff !== 8'h00) begin
            n_err++;
            $display("FAIL async_rst_abort: busy/done cycles=%0d diff=%h, want 0/00", dones, bus.diff);
        end
        start_op(8'hA5, 8'h5A);
        wait_done(lat, bc);
        n_cmp++;
        if (lat !== WIDTH || bus.diff !== 8'h4B || bus.borrow !== 1'b0) begin
            n_err++;
            $display("FAIL async_rst_recover: latency=%0d diff=%h borrow=%b, want %0d/4b/0",
                     lat, bus.diff, bus.borrow, WIDTH);
        end
    endtask

    task automatic test_random;
        int lat, bc;
        logic [7:0] av, bv, ed;
        logic       eb;
        for (int i = 0; i < 1000; i++) begin
            av = 8'($urandom_range(0, 255));
            bv = 8'($urandom_range(0, 255));
            ed = av - bv;
            eb = (av < bv);
            start_op(av, bv);
            wait_done(lat, bc);
            n_cmp++;
            if (lat !== WIDTH || bus.diff !== ed || bus.borrow !== eb) begin
                n_err++;
                $display("FAIL rand%0d: a=%h b=%h latency=%0d diff=%h borrow=%b, want %0d/%h/%b",
                         i, av, bv, lat, bus.diff, bus.borrow, WIDTH, ed, eb);
            end
        end
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        test_reset();
        test_vectors();
        test_ignore_start();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
